// File: rtl/multimode_fifo.sv
// Synchronous FIFO with a compile-time read mode (FWFT or registered read), programmable
// almost-full/almost-empty thresholds, an occupancy output and sticky overflow/underflow flags.
module multimode_fifo #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FWFT            = 1,
    parameter int unsigned RESET_AF_THRESH = (2**ADDR_WIDTH) / 4,
    parameter int unsigned RESET_AE_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   almost_full_thresh,
    input  logic [ADDR_WIDTH:0]   almost_empty_thresh,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LVL_W = ADDR_WIDTH + 1;

    // The threshold tie-off defaults must fit the 0..DEPTH level range.
    if (RESET_AF_THRESH > DEPTH || RESET_AE_THRESH > DEPTH || FWFT > 1) begin : g_param_check
        $error("multimode_fifo: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_level_nxt;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Accept rules: a pop frees the slot a same-cycle push on a full FIFO needs.
    always_comb begin
        w_pop_ok    = pop && !r_empty;
        w_push_ok   = push && (!r_full || w_pop_ok);
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_level        <= w_level_nxt;
            r_empty        <= (w_level_nxt == '0);
            r_full         <= (w_level_nxt == LVL_W'(DEPTH));
            r_almost_full  <= (w_level_nxt >= almost_full_thresh);
            r_almost_empty <= (w_level_nxt <= almost_empty_thresh);
            r_overflow     <= r_overflow  || (push && !w_push_ok);
            r_underflow    <= r_underflow || (pop && !w_pop_ok);
        end
    end

    // Storage is deliberately not reset; an edge that coincides with rst writes nothing.
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; zero while empty so reset/clear present rd_data = 0.
        assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
        assign rd_valid = !r_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else if (clear) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else if (w_pop_ok) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_multimode_fifo.sv
// Bench for multimode_fifo: a depth-4 FWFT instance driven from a vector table with a data
// scoreboard, and a depth-4 registered-read instance exercised by hand-written sequences.
module tb_multimode_fifo;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          c1, pu1, po1;
    logic [DW-1:0] wd1, rd1;
    logic [AW:0]   aft1, aet1, lv1;
    logic          rv1, e1, f1, ae1, af1, ov1, un1;

    logic          c0, pu0, po0;
    logic [DW-1:0] wd0, rd0;
    logic [AW:0]   aft0, aet0, lv0;
    logic          rv0, e0, f0, ae0, af0, ov0, un0;

    multimode_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clear(c1), .push(pu1), .wr_data(wd1), .pop(po1),
        .rd_data(rd1), .rd_valid(rv1), .almost_full_thresh(aft1), .almost_empty_thresh(aet1),
        .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1), .level(lv1),
        .overflow(ov1), .underflow(un1)
    );

    multimode_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clear(c0), .push(pu0), .wr_data(wd0), .pop(po0),
        .rd_data(rd0), .rd_valid(rv0), .almost_full_thresh(aft0), .almost_empty_thresh(aet0),
        .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0), .level(lv0),
        .overflow(ov0), .underflow(un0)
    );

    typedef struct {
        logic          push;
        logic          pop;
        logic          clr;
        logic [DW-1:0] wd;
        logic [AW:0]   aft;
        logic [AW:0]   aet;
        logic [AW:0]   lvl;
        logic          e;
        logic          f;
        logic          af;
        logic          ae;
        logic          ov;
        logic          un;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sbq[$];
    int            mlvl;
    int            n_cmp;
    int            n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic pu, input logic po, input logic cl, input logic [DW-1:0] wd,
                       input logic [AW:0] aft, input logic [AW:0] aet, input logic [AW:0] lvl,
                       input logic e, input logic f, input logic af, input logic ae,
                       input logic ov, input logic un);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.wd = wd; v.aft = aft; v.aet = aet;
        v.lvl = lvl; v.e = e; v.f = f; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    // Drive one vector, check head data against the scoreboard before the edge, flags after.
    task automatic apply(input vec_t v, input int idx);
        logic          pop_ok;
        logic          push_ok;
        logic [DW-1:0] exp_d;
        pu1 = v.push; po1 = v.pop; c1 = v.clr; wd1 = v.wd; aft1 = v.aft; aet1 = v.aet;
        @(negedge clk);
        if (v.clr) begin
            sbq.delete();
            mlvl = 0;
        end else begin
            pop_ok  = v.pop && (mlvl > 0);
            push_ok = v.push && ((mlvl < 4) || pop_ok);
            if (pop_ok) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("v%0d_sb_underrun", idx), 32'(rd1), 32'hdead);
                end else begin
                    exp_d = sbq.pop_front();
                    chk($sformatf("v%0d_rd_data", idx), 32'(rd1), 32'(exp_d));
                end
            end
            if (push_ok) sbq.push_back(v.wd);
            mlvl = mlvl + int'(push_ok) - int'(pop_ok);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_level", idx), 32'(lv1), 32'(v.lvl));
        chk($sformatf("v%0d_empty", idx), 32'(e1), 32'(v.e));
        chk($sformatf("v%0d_full", idx), 32'(f1), 32'(v.f));
        chk($sformatf("v%0d_almost_full", idx), 32'(af1), 32'(v.af));
        chk($sformatf("v%0d_almost_empty", idx), 32'(ae1), 32'(v.ae));
        chk($sformatf("v%0d_overflow", idx), 32'(ov1), 32'(v.ov));
        chk($sformatf("v%0d_underflow", idx), 32'(un1), 32'(v.un));
        chk($sformatf("v%0d_rd_valid", idx), 32'(rv1), 32'(!v.e));
    endtask

    task automatic std_step(input logic pu, input logic po, input logic [DW-1:0] wd);
        pu0 = pu; po0 = po; wd0 = wd;
        @(posedge clk);
        #1;
        pu0 = 1'b0; po0 = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; mlvl = 0;
        rst = 1'b1;
        c1 = 0; pu1 = 0; po1 = 0; wd1 = '0; aft1 = 3'd3; aet1 = 3'd1;
        c0 = 0; pu0 = 0; po0 = 0; wd0 = '0; aft0 = 3'd3; aet0 = 3'd1;

        // push pop clr data aft aet | lvl e f af ae ov un
        add(0, 0, 0, 8'h00, 3, 1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 8'hA1, 3, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 8'hA2, 3, 1, 2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA3, 3, 1, 3, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'hA4, 3, 1, 4, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 8'hB5, 3, 1, 4, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 8'hC0, 3, 1, 4, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 8'h00, 3, 1, 3, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 8'h00, 3, 1, 2, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 8'h00, 3, 1, 1, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 3, 1, 0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 3, 1, 0, 1, 0, 0, 1, 1, 1);
        add(1, 1, 1, 8'hEE, 3, 1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 8'hD1, 3, 1, 1, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 5, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, 1, 8'h00, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 8'hE1, 1, 1, 1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 8'hE2, 1, 1, 2, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 1, 3, 2, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            add(1, 1, 0, 8'hF0 + 8'(k), 1, 1, 2, 0, 0, 1, 0, 0, 0);
        end
        add(0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 1, 0, 1, 0, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_level", 32'(lv1), 32'd0);
        chk("rst_empty", 32'(e1), 32'd1);
        chk("rst_full", 32'(f1), 32'd0);
        chk("rst_almost_empty", 32'(ae1), 32'd1);
        chk("rst_almost_full", 32'(af1), 32'd0);
        chk("rst_flags", 32'({ov1, un1}), 32'd0);
        chk("rst_rd_valid", 32'(rv1), 32'd0);
        chk("rst_rd_data", 32'(rd1), 32'd0);
        chk("rst_std_rd_data", 32'(rd0), 32'd0);
        chk("rst_std_rd_valid", 32'(rv0), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        pu1 = 0; po1 = 0; c1 = 0;

        // Registered-read instance: data appears one cycle after the pop edge, then holds.
        std_step(1, 0, 8'h11);
        chk("std_empty_after_push", 32'(e0), 32'd0);
        chk("std_rv_no_pop", 32'(rv0), 32'd0);
        std_step(1, 1, 8'h22);
        chk("std_rv_pop1", 32'(rv0), 32'd1);
        chk("std_rd_pop1", 32'(rd0), 32'h11);
        chk("std_level_pop1", 32'(lv0), 32'd1);
        std_step(0, 0, 8'h00);
        chk("std_rv_idle", 32'(rv0), 32'd0);
        chk("std_rd_hold", 32'(rd0), 32'h11);
        std_step(0, 1, 8'h00);
        chk("std_rd_pop2", 32'(rd0), 32'h22);
        chk("std_rv_pop2", 32'(rv0), 32'd1);
        chk("std_empty_pop2", 32'(e0), 32'd1);
        std_step(0, 1, 8'h00);
        chk("std_rv_dropped", 32'(rv0), 32'd0);
        chk("std_rd_hold2", 32'(rd0), 32'h22);
        chk("std_underflow", 32'(un0), 32'd1);

        // Async reset between edges, with state built up in the FWFT instance.
        po1 = 1; @(posedge clk); #1; po1 = 0;
        pu1 = 1; wd1 = 8'h61; @(posedge clk); #1;
        wd1 = 8'h62; @(posedge clk); #1;
        chk("pre_rst_level", 32'(lv1), 32'd2);
        chk("pre_rst_underflow", 32'(un1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(lv1), 32'd0);
        chk("async_empty", 32'(e1), 32'd1);
        chk("async_almost", 32'({af1, ae1}), 32'd1);
        chk("async_underflow", 32'(un1), 32'd0);
        chk("async_rd_valid", 32'(rv1), 32'd0);
        chk("async_rd_data", 32'(rd1), 32'd0);
        chk("async_std_underflow", 32'(un0), 32'd0);
        pu1 = 0;
        @(negedge clk);
        rst = 1'b0;
        pu1 = 1; wd1 = 8'h77; @(posedge clk); #1; pu1 = 0;
        chk("post_rst_rd_valid", 32'(rv1), 32'd1);
        chk("post_rst_rd_data", 32'(rd1), 32'h77);
        chk("post_rst_level", 32'(lv1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
